// File: rtl/sensor_scan_ctrl.sv
// Row/column scan sequencer for an integrating pixel sensor array: each pixel is
// selected, settled, held, digitised and streamed out over a valid/ready handshake.
module sensor_scan_ctrl #(
  parameter int N_ROWS    = 11,
  parameter int N_COLS    = 25,
  parameter int CNT_W     = 16,
  parameter int ADC_W     = 12,
  parameter int RST_CYC   = 100,
  parameter int PXRST_CYC = 10,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic [CNT_W-1:0]  acc_time,
  input  logic [CNT_W-1:0]  hold_time,
  output logic              adc_start,
  input  logic              adc_busy,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [ADC_W-1:0]  px_data,
  output logic [RW-1:0]     px_row,
  output logic [CW-1:0]     px_col,
  output logic [N_ROWS-1:0] row_sel,
  output logic [N_COLS-1:0] col_sel,
  output logic              iv_rst,
  output logic              iv_hold,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACCUM    = 3'd1;
  localparam logic [2:0] SELECT   = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] CONVERT  = 3'd4;
  localparam logic [2:0] OUTPUT   = 3'd5;
  localparam logic [2:0] PIXRST   = 3'd6;
  localparam logic [2:0] FRAMERST = 3'd7;

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  acc_l;
  logic [CNT_W-1:0]  hold_l;
  logic [CNT_W-1:0]  limit;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic              seen_hi;
  logic              started;
  logic              cnt_last;
  logic              last_px;
  logic [N_ROWS-1:0] row_oh;
  logic [N_COLS-1:0] col_oh;

  // A zero duration still costs one cycle, so the compare is against cnt+1.
  function automatic logic cnt_done(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lim);
    return ({1'b0, c} + (CNT_W+1)'(1)) >= {1'b0, lim};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    case (state)
      ACCUM:    limit = acc_l;
      HOLD:     limit = hold_l;
      PIXRST:   limit = CNT_W'(PXRST_CYC);
      FRAMERST: limit = CNT_W'(RST_CYC);
      default:  limit = '0;
    endcase
  end

  assign cnt_last = cnt_done(cnt, limit);
  assign last_px  = (row == RW'(N_ROWS-1)) && (col == CW'(N_COLS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_l      <= '0;
      hold_l     <= '0;
      row        <= '0;
      col        <= '0;
      seen_hi    <= 1'b0;
      started    <= 1'b0;
      px_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc_l  <= acc_time;
          hold_l <= hold_time;
          row    <= '0;
          col    <= '0;
          cnt    <= '0;
          state  <= ACCUM;
        end
        ACCUM: if (cnt_last) begin
          cnt   <= '0;
          state <= SELECT;
        end else cnt <= cnt + CNT_W'(1);
        SELECT: begin
          cnt   <= '0;
          state <= HOLD;
        end
        HOLD: if (cnt_last) begin
          cnt     <= '0;
          started <= 1'b0;
          seen_hi <= 1'b0;
          state   <= CONVERT;
        end else cnt <= cnt + CNT_W'(1);
        // Busy already high on entry counts as the high phase; data is taken on the first low cycle after it.
        CONVERT: begin
          started <= 1'b1;
          if (adc_busy) seen_hi <= 1'b1;
          else if (seen_hi) begin
            px_data <= adc_data;
            state   <= OUTPUT;
          end
        end
        OUTPUT: if (px_ready) begin
          cnt   <= '0;
          state <= PIXRST;
        end
        PIXRST: if (cnt_last) begin
          cnt <= '0;
          if (last_px) begin
            row   <= '0;
            col   <= '0;
            state <= FRAMERST;
          end else begin
            if (col == CW'(N_COLS-1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else col <= col + CW'(1);
            state <= SELECT;
          end
        end else cnt <= cnt + CNT_W'(1);
        FRAMERST: if (cnt_last) begin
          cnt        <= '0;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + CNT_W'(1);
          if (cont) begin
            acc_l  <= acc_time;
            hold_l <= hold_time;
            state  <= ACCUM;
          end else state <= IDLE;
        end else cnt <= cnt + CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    row_oh = '0;
    col_oh = '0;
    for (int i = 0; i < N_ROWS; i++) row_oh[i] = (row == RW'(i));
    for (int j = 0; j < N_COLS; j++) col_oh[j] = (col == CW'(j));
  end

  // IDLE and FRAMERST share the all-lines-on, integrator-clamped levels.
  always_comb begin
    row_sel = '1;
    col_sel = '1;
    iv_rst  = 1'b1;
    iv_hold = 1'b0;
    case (state)
      ACCUM: begin
        row_sel = '0;
        col_sel = '0;
        iv_rst  = 1'b0;
      end
      SELECT, HOLD: begin
        row_sel = row_oh;
        col_sel = col_oh;
        iv_rst  = 1'b0;
      end
      CONVERT, OUTPUT: begin
        row_sel = row_oh;
        col_sel = col_oh;
        iv_rst  = 1'b0;
        iv_hold = 1'b1;
      end
      PIXRST: begin
        row_sel = row_oh;
        col_sel = col_oh;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign px_valid  = (state == OUTPUT);
  assign adc_start = (state == CONVERT) && !started;
  assign px_row    = row;
  assign px_col    = col;

endmodule
